// File: rtl/result_arb_pkg.sv
// rtl/result_arb_pkg.sv - shared types and width helpers for the result send arbiter
// RESULT_ARB_TAG_EN reserves the low TAG_BITS of the forwarded data for the winner index.
package result_arb_pkg;

  localparam int TAG_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } arb_state_e;

  function automatic int bw_f(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction

  function automatic int payload_bits_f(input int max_bits);
`ifdef RESULT_ARB_TAG_EN
    return max_bits - TAG_BITS;
`else
    return max_bits;
`endif
  endfunction

endpackage

// File: rtl/result_send_arbiter_if.sv
// rtl/result_send_arbiter_if.sv - requester-side and sender-side signals of the arbiter
// Payload width follows RESULT_ARB_TAG_EN through payload_bits_f.
interface result_send_arbiter_if
  import result_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS   = 4,
  parameter int MAX_BITS_TO_SEND = 128
);
  localparam int BW = bw_f(MAX_BITS_TO_SEND);
  localparam int PB = payload_bits_f(MAX_BITS_TO_SEND);

  logic [NUM_REQUESTERS-1:0]    req;
  logic [NUM_REQUESTERS*PB-1:0] req_data;
  logic [NUM_REQUESTERS*BW-1:0] req_bits;
  logic [NUM_REQUESTERS-1:0]    ack;
  logic                         new_data_to_send;
  logic [MAX_BITS_TO_SEND-1:0]  data;
  logic [BW-1:0]                number_of_bits_to_send;
  logic                         busy;

  modport master (
    output req, req_data, req_bits,
    input  ack, new_data_to_send, data, number_of_bits_to_send, busy
  );

  modport slave (
    input  req, req_data, req_bits,
    output ack, new_data_to_send, data, number_of_bits_to_send, busy
  );

endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin find-first-set starting after last_grant
module rr_priority_picker #(
  parameter int NUM_REQUESTERS = 4,
  parameter int IW             = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IW-1:0]             last_grant,
  output logic [IW-1:0]             winner,
  output logic                      valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = NUM_REQUESTERS; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_REQUESTERS;
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_send_arbiter.sv
// rtl/result_send_arbiter.sv - round-robin arbiter sharing one multiple_byte_sender among solver cores
// RESULT_ARB_TAG_EN prepends the winner index as an 8-bit tag in data[7:0].
module result_send_arbiter
  import result_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS   = 4,
  parameter int MAX_BITS_TO_SEND = 128,
  parameter int GAP_CYCLES       = 4
) (
  input logic                 clk,
  input logic                 reset,
  result_send_arbiter_if.slave bus
);

  localparam int BW = bw_f(MAX_BITS_TO_SEND);
  localparam int PB = payload_bits_f(MAX_BITS_TO_SEND);
  localparam int IW = $clog2(NUM_REQUESTERS);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_e                  state_q, state_d;
  logic [IW-1:0]               last_grant_q, last_grant_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic [NUM_REQUESTERS-1:0]   ack_q, ack_d;
  logic                        push_q, push_d;
  logic [MAX_BITS_TO_SEND-1:0] data_q, data_d;
  logic [BW-1:0]               nbits_q, nbits_d;
  logic                        busy_q, busy_d;

  logic [IW-1:0] pick_winner;
  logic          pick_valid;
  logic [PB-1:0] sel_data;
  logic [BW-1:0] sel_bits;
  logic [BW-1:0] clamped;

  rr_priority_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .IW            (IW)
  ) u_picker (
    .req       (bus.req),
    .last_grant(last_grant_q),
    .winner    (pick_winner),
    .valid     (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    ack_d        = '0;
    push_d       = 1'b0;
    data_d       = data_q;
    nbits_d      = nbits_q;
    busy_d       = busy_q;

    sel_data = bus.req_data[pick_winner*PB +: PB];
    sel_bits = bus.req_bits[pick_winner*BW +: BW];
    clamped  = (sel_bits > BW'(PB)) ? BW'(PB) : sel_bits;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          last_grant_d = pick_winner;
          ack_d        = NUM_REQUESTERS'(1) << pick_winner;
          busy_d       = 1'b1;
          state_d      = ST_SEND;
          // Zero-length results are acknowledged but never reach the sender.
          if (sel_bits != '0) begin
            push_d = 1'b1;
`ifdef RESULT_ARB_TAG_EN
            data_d  = {sel_data, TAG_BITS'(pick_winner)};
            nbits_d = clamped + BW'(TAG_BITS);
`else
            data_d  = sel_data;
            nbits_d = clamped;
`endif
          end
        end
      end
      ST_SEND: begin
        gap_d   = GW'(GAP_CYCLES);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NUM_REQUESTERS - 1);
      gap_q        <= '0;
      ack_q        <= '0;
      push_q       <= 1'b0;
      data_q       <= '0;
      nbits_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      ack_q        <= ack_d;
      push_q       <= push_d;
      data_q       <= data_d;
      nbits_q      <= nbits_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ack                    = ack_q;
  assign bus.new_data_to_send       = push_q;
  assign bus.data                   = data_q;
  assign bus.number_of_bits_to_send = nbits_q;
  assign bus.busy                   = busy_q;

endmodule

// File: tb/tb_result_send_arbiter.sv
// tb/tb_result_send_arbiter.sv - scoreboard bench for result_send_arbiter, either RESULT_ARB_TAG_EN build
module tb_result_send_arbiter;
  import result_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 128;
  localparam int GAP  = 4;
  localparam int BW   = bw_f(MAXB);
  localparam int PB   = payload_bits_f(MAXB);

  typedef struct {
    logic [MAXB-1:0] data;
    logic [BW-1:0]   bits;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  result_send_arbiter_if #(.NUM_REQUESTERS(N), .MAX_BITS_TO_SEND(MAXB)) bus ();

  result_send_arbiter #(
    .NUM_REQUESTERS  (N),
    .MAX_BITS_TO_SEND(MAXB),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic exp_t model(input int core, input logic [MAXB-1:0] payload, input int bits);
    exp_t e;
    int   b;
    b = (bits > PB) ? PB : bits;
`ifdef RESULT_ARB_TAG_EN
    e.data = {payload[PB-1:0], 8'(core)};
    e.bits = BW'(b + 8);
`else
    e.data = payload;
    e.bits = BW'(b);
`endif
    return e;
  endfunction

  task automatic drive(input int core, input logic [MAXB-1:0] payload, input int bits);
    bus.req[core]                 = 1'b1;
    bus.req_data[core*PB +: PB]   = payload[PB-1:0];
    bus.req_bits[core*BW +: BW]   = BW'(bits);
  endtask

  task automatic clear_reqs();
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_bits = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.ack, bus.new_data_to_send, bus.busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {bus.ack, bus.new_data_to_send, bus.busy});
    end
    total++;
    if (bus.data !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", bus.data);
    end
    total++;
    if (bus.number_of_bits_to_send !== '0) begin
      bad++;
      $display("FAIL reset_bits got=%0d want=0", bus.number_of_bits_to_send);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int   cnt;
    drive(2, 128'h1234, 16);
    sb.push_back(model(2, 128'h1234, 16));
    step();
    total++;
    if (bus.ack !== 4'b0100 || bus.new_data_to_send !== 1'b1) begin
      bad++;
      $display("FAIL single_latency ack=%b push=%b want ack=0100 push=1", bus.ack, bus.new_data_to_send);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL single_sb_empty");
    end else begin
      e = sb.pop_front();
      if ({bus.data, bus.number_of_bits_to_send} !== {e.data, e.bits}) begin
        bad++;
        $display("FAIL single_payload got=%h/%0d want=%h/%0d", bus.data, bus.number_of_bits_to_send, e.data, e.bits);
      end
    end
    bus.req[2] = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      step();
    end
    total++;
    if (cnt !== GAP + 1) begin
      bad++;
      $display("FAIL single_busy_len got=%0d want=%0d", cnt, GAP + 1);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   prev;
    int   c;
    do_reset();
    for (int i = 0; i < N; i++) drive(i, {4{32'hC0DE_0000 + 32'(i)}}, 8 * (i + 1));
    for (int k = 0; k < 5; k++)
      sb.push_back(model(k % N, {4{32'hC0DE_0000 + 32'(k % N)}}, 8 * ((k % N) + 1)));
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      c = 0;
      if (k > 0) step();
      while (!bus.new_data_to_send && c < 20) begin
        step();
        c++;
      end
      total++;
      if (!bus.new_data_to_send) begin
        bad++;
        $display("FAIL sat_timeout grant=%0d", k);
      end else begin
        if (bus.ack !== 4'(1 << (k % N))) begin
          bad++;
          $display("FAIL sat_order grant=%0d got=%b want core %0d", k, bus.ack, k % N);
        end
        if (k > 0 && cyc - prev !== GAP + 2) begin
          bad++;
          $display("FAIL sat_spacing grant=%0d got=%0d want=%0d", k, cyc - prev, GAP + 2);
        end
        prev = cyc;
        e = sb.pop_front();
        if ({bus.data, bus.number_of_bits_to_send} !== {e.data, e.bits}) begin
          bad++;
          $display("FAIL sat_payload grant=%0d got=%h/%0d want=%h/%0d", k, bus.data, bus.number_of_bits_to_send, e.data, e.bits);
        end
      end
    end
    clear_reqs();
  endtask

  task automatic test_zero_count();
    exp_t e;
    int   c;
    do_reset();
    drive(1, 128'hDEAD, 0);
    step();
    total++;
    if (bus.ack !== 4'b0010 || bus.new_data_to_send !== 1'b0) begin
      bad++;
      $display("FAIL zero_ack ack=%b push=%b want ack=0010 push=0", bus.ack, bus.new_data_to_send);
    end
    bus.req[1] = 1'b0;
    drive(3, 128'h55, 8);
    sb.push_back(model(3, 128'h55, 8));
    c = 0;
    do begin
      step();
      c++;
    end while (bus.ack == '0 && c < 20);
    total++;
    if (c !== GAP + 2 || bus.ack !== 4'b1000 || bus.new_data_to_send !== 1'b1) begin
      bad++;
      $display("FAIL zero_next_grant cycles=%0d ack=%b push=%b want cycles=%0d ack=1000 push=1", c, bus.ack, bus.new_data_to_send, GAP + 2);
    end
    e = sb.pop_front();
    total++;
    if ({bus.data, bus.number_of_bits_to_send} !== {e.data, e.bits}) begin
      bad++;
      $display("FAIL zero_next_payload got=%h/%0d want=%h/%0d", bus.data, bus.number_of_bits_to_send, e.data, e.bits);
    end
    bus.req[3] = 1'b0;
  endtask

  task automatic send_one(input string name, input int core, input logic [MAXB-1:0] payload, input int bits,
                          output logic ok);
    exp_t e;
    int   c;
    c = 0;
    while (bus.busy && c < 20) begin
      step();
      c++;
    end
    drive(core, payload, bits);
    sb.push_back(model(core, payload, bits));
    c = 0;
    do begin
      step();
      c++;
    end while (!bus.new_data_to_send && c < 20);
    bus.req[core] = 1'b0;
    e  = sb.pop_front();
    ok = 1'b1;
    total++;
    if (!bus.new_data_to_send || {bus.data, bus.number_of_bits_to_send} !== {e.data, e.bits}) begin
      bad++;
      ok = 1'b0;
      $display("FAIL %s_payload got=%h/%0d want=%h/%0d", name, bus.data, bus.number_of_bits_to_send, e.data, e.bits);
    end
  endtask

  task automatic test_clamp();
    logic ok;
    send_one("clamp", 0, {4{32'hF00D_BEEF}}, 200, ok);
    total++;
    if (bus.number_of_bits_to_send !== BW'(128)) begin
      bad++;
      $display("FAIL clamp_bits got=%0d want=128", bus.number_of_bits_to_send);
    end
  endtask

  task automatic test_tag();
    logic        ok;
    logic [15:0] low;
    send_one("tag", 3, 128'hAB, 8, ok);
    low = bus.data[15:0];
    total++;
`ifdef RESULT_ARB_TAG_EN
    if (low !== 16'hAB03 || bus.number_of_bits_to_send !== BW'(16)) begin
      bad++;
      $display("FAIL tag_fields got=%h/%0d want=ab03/16", low, bus.number_of_bits_to_send);
    end
`else
    if (low !== 16'h00AB || bus.number_of_bits_to_send !== BW'(8)) begin
      bad++;
      $display("FAIL tag_fields got=%h/%0d want=00ab/8", low, bus.number_of_bits_to_send);
    end
`endif
  endtask

  task automatic test_reset_during_send();
    exp_t e;
    int   c;
    do_reset();
    drive(1, 128'h111, 16);
    drive(2, 128'h222, 16);
    sb.push_back(model(1, 128'h111, 16));
    sb.push_back(model(1, 128'h111, 16));
    step();
    e = sb.pop_front();
    total++;
    if (bus.ack !== 4'b0010 || {bus.data, bus.number_of_bits_to_send} !== {e.data, e.bits}) begin
      bad++;
      $display("FAIL rst_send_first ack=%b got=%h want=%h", bus.ack, bus.data, e.data);
    end
    reset = 1'b1;
    step();
    total++;
    if ({bus.ack, bus.new_data_to_send, bus.busy, bus.data, bus.number_of_bits_to_send} !== '0) begin
      bad++;
      $display("FAIL rst_send_outputs ack=%b push=%b busy=%b data=%h bits=%0d want all zero",
               bus.ack, bus.new_data_to_send, bus.busy, bus.data, bus.number_of_bits_to_send);
    end
    reset = 1'b0;
    c = 0;
    do begin
      step();
      c++;
    end while (bus.ack == '0 && c < 20);
    e = sb.pop_front();
    total++;
    if (c !== 1 || bus.ack !== 4'b0010 || {bus.data, bus.number_of_bits_to_send} !== {e.data, e.bits}) begin
      bad++;
      $display("FAIL rst_regrant cycles=%0d ack=%b got=%h want cycles=1 ack=0010 data=%h", c, bus.ack, bus.data, e.data);
    end
    clear_reqs();
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_single();
    test_saturation();
    test_zero_count();
    test_clamp();
    test_tag();
    test_reset_during_send();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_send_arbiter.md
# result_send_arbiter

Round-robin arbiter that shares one `multiple_byte_sender` among `NUM_REQUESTERS` solver cores. Each core presents a result word and bit count with a level request; the arbiter selects one per slot and forwards it as a single-cycle `new_data_to_send` pulse. It enforces a minimum spacing between pushes so the sender's buffer intake and 3-cycle push holdoff are never violated. It sits between the puzzle-solving cores and the UART transmit path.

## Interface
- `NUM_REQUESTERS`, 4, number of requesting cores (≥2).
- `MAX_BITS_TO_SEND`, 128, output data width; must match the downstream sender.
- `GAP_CYCLES`, 4, idle cycles after each push before the next arbitration (≥1).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  `NUM_REQUESTERS`  per-core level request; held until the matching `ack`.
- `req_data`  in  `NUM_REQUESTERS*PAYLOAD_BITS`  flattened payloads, core i at `[i*PAYLOAD_BITS +: PAYLOAD_BITS]`, little endian.
- `req_bits`  in  `NUM_REQUESTERS*BW`  flattened bit counts, `BW = $clog2(MAX_BITS_TO_SEND+1)`.
- `ack`  out  `NUM_REQUESTERS`  one-hot, single-cycle acceptance pulse.
- `new_data_to_send`  out  1  single-cycle push pulse to the sender.
- `data`  out  `MAX_BITS_TO_SEND`  forwarded payload.
- `number_of_bits_to_send`  out  `BW`  forwarded bit count.
- `busy`  out  1  high in SEND and GAP.

`PAYLOAD_BITS` is `MAX_BITS_TO_SEND` normally and `MAX_BITS_TO_SEND-8` with tagging (see Configuration).

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - If `req` is nonzero, pick the first set bit scanning upward (wrapping) from `last_grant+1`.
  - Latch that core's payload and bit count. Set `last_grant` to the winner and go to SEND.
  - If `req` is zero, stay in IDLE.
- SEND, one cycle:
  - `ack[winner]=1`.
  - If the latched count is nonzero, `new_data_to_send=1` and `data`/`number_of_bits_to_send` present the latched values.
  - If the latched count is zero, the request is acked but not forwarded (`new_data_to_send=0`).
  - Load the gap counter with `GAP_CYCLES` and go to GAP.
- GAP: decrement the counter; go to IDLE when it reaches 0. `req` is ignored in GAP.
- A bit count above `PAYLOAD_BITS` is clamped to `PAYLOAD_BITS`. Payload bits above the count are forwarded unmodified; the sender ignores them.
- The requester must drop `req`, or present a new result, in the cycle after `ack`. The arbiter never re-samples a core before the next IDLE.
- Fairness: a core that requests continuously waits at most `NUM_REQUESTERS-1` grants.

## Timing
- Reset values:
  - Outputs: `ack=0`, `new_data_to_send=0`, `data=0`, `number_of_bits_to_send=0`, `busy=0`.
  - Internal: state IDLE, `last_grant=NUM_REQUESTERS-1` (core 0 has first priority), gap counter 0.
- Latency: request seen in IDLE at cycle T gives `ack` and `new_data_to_send` at T+1.
- Push-to-push spacing is `GAP_CYCLES+2` cycles under saturation. With the default this is 6, which exceeds the sender's 3-cycle holdoff.
- Simultaneous requests in one IDLE cycle are resolved purely by round-robin order; no core is lost.
- Reset asserted in any state: all outputs go low the next cycle. An in-flight push is not emitted, and its requester keeps `req` high and is re-arbitrated.
- The arbiter does not track the sender's buffer occupancy. Sustained load must stay within `BUFFER_SIZE`; this is a system-level requirement.

## Configuration
- Macro: `RESULT_ARB_TAG_EN`.
- Defined:
  - `data = {payload, 8'(winner index)}`, so the tag is the first UART byte after the length.
  - `number_of_bits_to_send = clamped count + 8`.
  - Zero-count requests are still dropped.
  - `PAYLOAD_BITS = MAX_BITS_TO_SEND-8`.
- Undefined: no tag is added; `data = payload`, bits = clamped count; `PAYLOAD_BITS = MAX_BITS_TO_SEND`.

## Structure
- Shared package `result_arb_pkg`:
  - State encoding (IDLE/SEND/GAP).
  - A `BW` width function.
  - A `PAYLOAD_BITS` function keyed on the tag macro.
  - The tag width constant (8).
- Sub-module `rr_priority_picker`: combinational rotate plus find-first-set. Takes `req` and `last_grant`; returns the winner index and a valid flag.

## Test plan
- Single request: core 2 asserts `req` with data `0x1234` and 16 bits. Expect `ack[2]` and a push of `0x1234`/16 one cycle later, with `busy` high for `GAP_CYCLES+1` cycles.
- All four cores request continuously from reset. Expect grant order 0,1,2,3,0 and pushes exactly 6 cycles apart.
- Zero-count request from core 1. Expect `ack[1]`, no `new_data_to_send`, and the next grant after GAP.
- Core 0 requests 200 bits with `MAX_BITS_TO_SEND=128`. Expect `number_of_bits_to_send=128`; with `RESULT_ARB_TAG_EN`, expect 128 (120+8).
- Tag build, core 3 sends `0xAB` with 8 bits. Expect `data[7:0]=0x03`, `data[15:8]=0xAB`, bits=16.
- Reset asserted during SEND. Expect outputs low next cycle, `last_grant` back to 3, and the same core re-granted first after reset.
